dflow_generator_ctrl: RTL and testbench
=======================================

Name: dflow_generator_ctrl

Overview:
Run-control sequencer for dflow_generator_datapath. It takes a software start/abort and latched configuration, then drives the datapath's sw_rst, start_store, start_replay and address window. The sequence is: soft reset, wait for QDR calibration, store N tuples, drain, then replay K passes. It sits between the AXI-lite register block and the datapath, and returns status and counters to the registers.

Parameters:
QDR_ADDR_WIDTH, 19, width of the memory address window
REPLAY_COUNT_WIDTH, 32, width of the replay pass counter
STORE_CNT_WIDTH, 32, width of the stored-tuple counter
RST_CYCLES, 16, number of cycles sw_rst is held high
DRAIN_CYCLES, 64, cycles between store end and replay start (QDR write flush)
WDOG_CYCLES, 1048576, replay watchdog limit (optional feature only)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start pulse
cfg_abort  in  1  one-cycle abort pulse
cfg_store_num  in  STORE_CNT_WIDTH  tuples to store; 0 = fill the window
cfg_replay_count  in  REPLAY_COUNT_WIDTH  replay passes; 0 = loop until abort
cfg_addr_low  in  QDR_ADDR_WIDTH  window base
cfg_addr_high  in  QDR_ADDR_WIDTH  window top (inclusive)
init_calib_complete  in  1  QDR calibration done
tuple_in_vld  in  1  datapath tuple input valid
tuple_in_ready  in  1  datapath tuple input ready
compelete_replay  in  1  datapath end-of-replay level
sw_rst  out  1  datapath soft reset
start_store  out  1  datapath store enable
start_replay  out  1  datapath replay enable
mem_addr_low  out  QDR_ADDR_WIDTH  latched window base
mem_addr_high  out  QDR_ADDR_WIDTH  latched window top
busy  out  1  state != IDLE and state != DONE
done  out  1  high in DONE
cfg_err  out  1  sticky; set when the window is invalid at start
abort_flag  out  1  sticky; set by abort
timeout_err  out  1  sticky; set by watchdog (optional feature)
state_o  out  3  current state encoding
stored_cnt  out  STORE_CNT_WIDTH  handshakes counted in STORE
replay_iter  out  REPLAY_COUNT_WIDTH  completed replay passes

Behaviour:
- Reset (async, resetn=0): all outputs 0 and state IDLE. Counters and latched configuration are cleared.
- Encodings: IDLE=0, RST=1, CALIB=2, STORE=3, DRAIN=4, REPLAY=5, REARM=6, DONE=7.
- IDLE or DONE + cfg_start:
  - If cfg_addr_high < cfg_addr_low: set cfg_err and go to IDLE.
  - Otherwise: latch all cfg_* inputs; clear cfg_err, abort_flag, timeout_err, stored_cnt and replay_iter; go to RST.
- cfg_start in any other state is ignored.
- Store limit, computed at latch time:
  - cap = high - low + 1, computed at QDR_ADDR_WIDTH+1 bits.
  - limit = cfg_store_num if nonzero and <= cap; otherwise cap.
- RST: sw_rst=1 for exactly RST_CYCLES cycles, then CALIB.
- CALIB: outputs low; move to STORE on the first cycle init_calib_complete=1.
- STORE:
  - start_store=1.
  - stored_cnt increments on every cycle with tuple_in_vld & tuple_in_ready.
  - When the increment makes stored_cnt == limit, start_store drops on the next cycle and the state moves to DRAIN.
  - stored_cnt never exceeds limit.
- DRAIN: outputs low; wait DRAIN_CYCLES, then REPLAY.
- REPLAY:
  - start_replay=1.
  - On a rising edge of compelete_replay (registered edge detect), replay_iter increments.
  - If cfg_replay_count != 0 and the new replay_iter == cfg_replay_count: go to DONE.
  - Otherwise go to REARM.
- REARM:
  - start_replay=0; hold until compelete_replay=0, minimum 1 cycle.
  - Then return to REPLAY.
- replay_iter saturates at all-ones.
- DONE: done=1 and start_replay=0; hold until cfg_start.
- cfg_abort in any non-IDLE state:
  - Next state is IDLE and abort_flag is set.
  - start_store and start_replay drop on the next edge.
  - sw_rst is pulsed for 1 cycle.
- cfg_abort and cfg_start in the same cycle: abort wins.
- mem_addr_low and mem_addr_high hold the latched values from RST until the next accepted start.
- Control outputs are registered: one-cycle latency from the state change.

Optional Feature:
Macro DFLOW_CTRL_WATCHDOG_EN.
- Defined:
  - A counter runs in REPLAY and is cleared on each compelete_replay rising edge and on entry to REPLAY.
  - Reaching WDOG_CYCLES sets timeout_err, pulses sw_rst for 1 cycle, and goes to IDLE.
- Undefined: no counter; timeout_err is tied to 0.

Test Plan:
1. Reset mid-REPLAY (resetn low for 3 cycles) -> all outputs 0 immediately (async), state_o=0.
2. low=0, high=0x0FFF, store_num=100, replay_count=3, calib=1, vld=ready=1 continuously:
   - sw_rst high for 16 cycles; start_store high for exactly 100 handshakes; stored_cnt=100.
   - start_replay rises 64 cycles later.
   - After 3 compelete_replay pulses: done=1, replay_iter=3.
3. store_num=0, low=0x10, high=0x1F -> limit=16; start_store ends after 16 handshakes.
4. high=5, low=9 at start -> cfg_err=1, state stays IDLE, sw_rst never asserted.
5. Abort during STORE, with ready toggling every other cycle -> next cycle state IDLE, start_store=0, 1-cycle sw_rst, abort_flag=1. A new start clears abort_flag.
6. With DFLOW_CTRL_WATCHDOG_EN, WDOG_CYCLES=100, compelete_replay never asserted -> timeout_err=1 and IDLE 100 cycles after REPLAY entry.

Source files
------------

// File: rtl/dflow_generator_ctrl.sv
// Run-control sequencer for dflow_generator_datapath: soft reset, calibration wait, store, drain, replay passes.
// Optional replay watchdog enabled by defining DFLOW_CTRL_WATCHDOG_EN.
module dflow_generator_ctrl #(
  parameter int QDR_ADDR_WIDTH     = 19,
  parameter int REPLAY_COUNT_WIDTH = 32,
  parameter int STORE_CNT_WIDTH    = 32,
  parameter int RST_CYCLES         = 16,
  parameter int DRAIN_CYCLES       = 64,
  parameter int WDOG_CYCLES        = 1048576
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic [STORE_CNT_WIDTH-1:0]    cfg_store_num,
  input  logic [REPLAY_COUNT_WIDTH-1:0] cfg_replay_count,
  input  logic [QDR_ADDR_WIDTH-1:0]     cfg_addr_low,
  input  logic [QDR_ADDR_WIDTH-1:0]     cfg_addr_high,
  input  logic                          init_calib_complete,
  input  logic                          tuple_in_vld,
  input  logic                          tuple_in_ready,
  input  logic                          compelete_replay,
  output logic                          sw_rst,
  output logic                          start_store,
  output logic                          start_replay,
  output logic [QDR_ADDR_WIDTH-1:0]     mem_addr_low,
  output logic [QDR_ADDR_WIDTH-1:0]     mem_addr_high,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err,
  output logic                          abort_flag,
  output logic                          timeout_err,
  output logic [2:0]                    state_o,
  output logic [STORE_CNT_WIDTH-1:0]    stored_cnt,
  output logic [REPLAY_COUNT_WIDTH-1:0] replay_iter
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, RST = 3'd1, CALIB = 3'd2, STORE = 3'd3,
    DRAIN = 3'd4, REPLAY = 3'd5, REARM = 3'd6, DONE = 3'd7
  } state_t;

  // Limit arithmetic wide enough for both the window size and the store counter
  localparam int LW = (STORE_CNT_WIDTH > QDR_ADDR_WIDTH + 1) ? STORE_CNT_WIDTH : QDR_ADDR_WIDTH + 1;

  state_t                        state, nxt;
  logic [31:0]                   tmr;
  logic [LW-1:0]                 limit, limit_new, cap, num_ext;
  logic [REPLAY_COUNT_WIDTH-1:0] rc_q, iter_inc;
  logic                          comp_q, rise, hs;
  logic                          latch, set_err, do_abort, do_tmo;

  assign hs        = tuple_in_vld & tuple_in_ready;
  assign rise      = compelete_replay & ~comp_q;
  assign iter_inc  = (&replay_iter) ? replay_iter : replay_iter + 1'b1;
  assign cap       = LW'(cfg_addr_high) - LW'(cfg_addr_low) + LW'(1);
  assign num_ext   = LW'(cfg_store_num);
  assign limit_new = (num_ext != '0 && num_ext <= cap) ? num_ext : cap;
  assign state_o   = state;

  always_comb begin
    nxt      = state;
    latch    = 1'b0;
    set_err  = 1'b0;
    do_abort = 1'b0;
    do_tmo   = 1'b0;
    case (state)
      IDLE, DONE: if (cfg_start) begin
        if (cfg_addr_high < cfg_addr_low) begin
          set_err = 1'b1;
          nxt     = IDLE;
        end else begin
          latch = 1'b1;
          nxt   = RST;
        end
      end
      RST:    if (tmr == 32'(RST_CYCLES - 1)) nxt = CALIB;
      CALIB:  if (init_calib_complete) nxt = STORE;
      STORE:  if (hs && (LW'(stored_cnt) + LW'(1) == limit)) nxt = DRAIN;
      DRAIN:  if (tmr == 32'(DRAIN_CYCLES - 1)) nxt = REPLAY;
      REPLAY: begin
        if (rise) begin
          nxt = (rc_q != '0 && iter_inc == rc_q) ? DONE : REARM;
`ifdef DFLOW_CTRL_WATCHDOG_EN
        end else if (tmr == 32'(WDOG_CYCLES - 1)) begin
          do_tmo = 1'b1;
          nxt    = IDLE;
`endif
        end
      end
      REARM:  if (!compelete_replay) nxt = REPLAY;
      default: nxt = IDLE;
    endcase
    // Abort overrides everything, including a simultaneous start
    if (cfg_abort) begin
      nxt      = IDLE;
      latch    = 1'b0;
      set_err  = 1'b0;
      do_tmo   = 1'b0;
      do_abort = (state != IDLE);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      tmr           <= '0;
      comp_q        <= 1'b0;
      sw_rst        <= 1'b0;
      start_store   <= 1'b0;
      start_replay  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_err       <= 1'b0;
      abort_flag    <= 1'b0;
      mem_addr_low  <= '0;
      mem_addr_high <= '0;
      rc_q          <= '0;
      limit         <= '0;
      stored_cnt    <= '0;
      replay_iter   <= '0;
    end else begin
      state        <= nxt;
      comp_q       <= compelete_replay;
      // Timer restarts on every state change; RST, DRAIN and the watchdog share it
      tmr          <= (nxt != state) ? '0 : tmr + 32'd1;
      sw_rst       <= (nxt == RST) | do_abort | do_tmo;
      start_store  <= (nxt == STORE);
      start_replay <= (nxt == REPLAY);
      busy         <= (nxt != IDLE) && (nxt != DONE);
      done         <= (nxt == DONE);
      if (latch) begin
        mem_addr_low  <= cfg_addr_low;
        mem_addr_high <= cfg_addr_high;
        rc_q          <= cfg_replay_count;
        limit         <= limit_new;
        stored_cnt    <= '0;
        replay_iter   <= '0;
        cfg_err       <= 1'b0;
        abort_flag    <= 1'b0;
      end else begin
        if (set_err)  cfg_err    <= 1'b1;
        if (do_abort) abort_flag <= 1'b1;
        if (state == STORE && hs && !cfg_abort)    stored_cnt  <= stored_cnt + 1'b1;
        if (state == REPLAY && rise && !cfg_abort) replay_iter <= iter_inc;
      end
    end
  end

`ifdef DFLOW_CTRL_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     timeout_err <= 1'b0;
    else if (latch)  timeout_err <= 1'b0;
    else if (do_tmo) timeout_err <= 1'b1;
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dflow_generator_ctrl.sv
// Bench for dflow_generator_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_dflow_generator_ctrl;
  localparam int AW = 19, RW = 32, SW = 32;
  localparam int RSTC = 16, DRNC = 64, WDOG = 100;

  logic clk, resetn, cfg_start, cfg_abort, init_calib_complete;
  logic tuple_in_vld, tuple_in_ready, compelete_replay;
  logic [SW-1:0] cfg_store_num;
  logic [RW-1:0] cfg_replay_count;
  logic [AW-1:0] cfg_addr_low, cfg_addr_high;
  logic sw_rst, start_store, start_replay, busy, done, cfg_err, abort_flag, timeout_err;
  logic [AW-1:0] mem_addr_low, mem_addr_high;
  logic [2:0] state_o;
  logic [SW-1:0] stored_cnt;
  logic [RW-1:0] replay_iter;

  dflow_generator_ctrl #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .resetn(resetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_store_num(cfg_store_num), .cfg_replay_count(cfg_replay_count),
    .cfg_addr_low(cfg_addr_low), .cfg_addr_high(cfg_addr_high),
    .init_calib_complete(init_calib_complete), .tuple_in_vld(tuple_in_vld),
    .tuple_in_ready(tuple_in_ready), .compelete_replay(compelete_replay),
    .sw_rst(sw_rst), .start_store(start_store), .start_replay(start_replay),
    .mem_addr_low(mem_addr_low), .mem_addr_high(mem_addr_high), .busy(busy), .done(done),
    .cfg_err(cfg_err), .abort_flag(abort_flag), .timeout_err(timeout_err), .state_o(state_o),
    .stored_cnt(stored_cnt), .replay_iter(replay_iter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int hs_mode = 0;
  bit comp_auto = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase name plus remaining-cycle countdowns
  int ms, left, mwd;
  longint mlim, mstored, miter, mrc, mlow, mhigh, mcap;
  bit merr, mabt, mtmo, mpulse, mprev, mrise;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms = 0; left = 0; mwd = 0; mlim = 0; mstored = 0; miter = 0; mrc = 0;
      mlow = 0; mhigh = 0; merr = 0; mabt = 0; mtmo = 0; mpulse = 0; mprev = 0;
    end else begin
      mpulse = 0;
      mrise  = compelete_replay && !mprev;
      if (cfg_abort) begin
        if (ms != 0) begin ms = 0; mabt = 1; mpulse = 1; end
      end else begin
        case (ms)
          0, 7: if (cfg_start) begin
            if (cfg_addr_high < cfg_addr_low) begin merr = 1; ms = 0; end
            else begin
              mlow = cfg_addr_low; mhigh = cfg_addr_high; mrc = cfg_replay_count;
              mcap = mhigh - mlow + 1;
              mlim = (cfg_store_num != 0 && longint'(cfg_store_num) <= mcap) ? longint'(cfg_store_num) : mcap;
              merr = 0; mabt = 0; mtmo = 0; mstored = 0; miter = 0;
              ms = 1; left = RSTC;
            end
          end
          1: begin left--; if (left == 0) ms = 2; end
          2: if (init_calib_complete) ms = 3;
          3: if (tuple_in_vld && tuple_in_ready) begin
            mstored++;
            if (mstored == mlim) begin ms = 4; left = DRNC; end
          end
          4: begin left--; if (left == 0) begin ms = 5; mwd = 0; end end
          5: begin
            if (mrise) begin
              if (miter != 64'hFFFF_FFFF) miter++;
              ms = (mrc != 0 && miter == mrc) ? 7 : 6;
            end else begin
`ifdef DFLOW_CTRL_WATCHDOG_EN
              mwd++;
              if (mwd == WDOG) begin mtmo = 1; mpulse = 1; ms = 0; end
`endif
            end
          end
          6: if (!compelete_replay) begin ms = 5; mwd = 0; end
          default: ms = 0;
        endcase
      end
      mprev = compelete_replay;
    end
  end

  // Per-cycle comparison against the model, plus output activity counters
  int n_sw = 0, n_st = 0, n_dr = 0, n_rp = 0;
  always @(posedge clk) begin
    logic [10:0] ev, av;
    #1;
    ev = {(ms == 1) || mpulse, ms == 3, ms == 5, ms != 0 && ms != 7, ms == 7, merr, mabt, mtmo, 3'(ms)};
    av = {sw_rst, start_store, start_replay, busy, done, cfg_err, abort_flag, timeout_err, state_o};
    chk("ctrl_vec", 64'(av), 64'(ev));
    chk("stored_cnt", 64'(stored_cnt), 64'(mstored));
    chk("replay_iter", 64'(replay_iter), 64'(miter));
    chk("addr_low", 64'(mem_addr_low), 64'(mlow));
    chk("addr_high", 64'(mem_addr_high), 64'(mhigh));
    if (sw_rst) n_sw++;
    if (start_store) n_st++;
    if (state_o == 3'd4) n_dr++;
    if (state_o == 3'd5) n_rp++;
  end

  // Tuple handshake driver
  initial begin
    tuple_in_vld = 0; tuple_in_ready = 0;
    forever begin
      @(negedge clk);
      case (hs_mode)
        0: begin tuple_in_vld = 1; tuple_in_ready = 1; end
        1: begin tuple_in_vld = ($urandom % 4) != 0; tuple_in_ready = $urandom % 2; end
        default: begin tuple_in_vld = 1; tuple_in_ready = ~tuple_in_ready; end
      endcase
    end
  end

  // Datapath end-of-replay emulation
  initial begin
    compelete_replay = 0;
    forever begin
      @(negedge clk);
      if (comp_auto && start_replay && !compelete_replay) begin
        repeat ($urandom_range(2, 8)) @(negedge clk);
        compelete_replay = 1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        compelete_replay = 0;
      end
    end
  end

  task automatic do_start(input int lo, input int hi, input int num, input int rc);
    @(negedge clk);
    cfg_addr_low = AW'(lo); cfg_addr_high = AW'(hi);
    cfg_store_num = SW'(num); cfg_replay_count = RW'(rc);
    cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); cfg_abort = 1;
    @(negedge clk); cfg_abort = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (state_o == s) return;
    end
    checks++; errors++;
    $display("FAIL %s: timeout waiting for state %0d, state is %0d", nm, s, state_o);
  endtask

  initial begin
    int sw0, st0, dr0, rp0;
    resetn = 0; cfg_start = 0; cfg_abort = 0; init_calib_complete = 0;
    cfg_store_num = 0; cfg_replay_count = 0; cfg_addr_low = 0; cfg_addr_high = 0;
    repeat (3) @(negedge clk);
    chk("rst_state", 64'(state_o), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_sw_rst", 64'(sw_rst), 0);
    resetn = 1;

    // Full run: 100 tuples, 3 replay passes
    init_calib_complete = 1; hs_mode = 0; comp_auto = 1;
    @(negedge clk); sw0 = n_sw; st0 = n_st; dr0 = n_dr;
    do_start(0, 'h0FFF, 100, 3);
    wait_state(3'd7, 3000, "t2_wait_done");
    @(negedge clk);
    chk("t2_done", 64'(done), 1);
    chk("t2_iter", 64'(replay_iter), 3);
    chk("t2_stored", 64'(stored_cnt), 100);
    chk("t2_swrst_cycles", 64'(n_sw - sw0), 16);
    chk("t2_store_cycles", 64'(n_st - st0), 100);
    chk("t2_drain_cycles", 64'(n_dr - dr0), 64);

    // store_num=0 fills the 16-entry window
    st0 = n_st;
    do_start('h10, 'h1F, 0, 1);
    wait_state(3'd7, 3000, "t3_wait_done");
    @(negedge clk);
    chk("t3_stored", 64'(stored_cnt), 16);
    chk("t3_store_cycles", 64'(n_st - st0), 16);

    // Inverted window
    sw0 = n_sw;
    do_start(9, 5, 10, 1);
    repeat (5) @(negedge clk);
    chk("t4_cfg_err", 64'(cfg_err), 1);
    chk("t4_state", 64'(state_o), 0);
    chk("t4_no_swrst", 64'(n_sw - sw0), 0);

    // Abort during STORE with ready toggling
    hs_mode = 2;
    do_start(0, 255, 50, 2);
    wait_state(3'd3, 200, "t5_wait_store");
    repeat (7) @(negedge clk);
    cfg_abort = 1;
    @(posedge clk); #1;
    chk("t5_state", 64'(state_o), 0);
    chk("t5_start_store", 64'(start_store), 0);
    chk("t5_sw_rst", 64'(sw_rst), 1);
    chk("t5_abort_flag", 64'(abort_flag), 1);
    @(negedge clk); cfg_abort = 0;
    @(posedge clk); #1;
    chk("t5_sw_rst_pulse", 64'(sw_rst), 0);
    do_start(0, 255, 5, 1);
    chk("t5_abort_cleared", 64'(abort_flag), 0);
    wait_state(3'd7, 2000, "t5_wait_done");

    // Async reset mid-REPLAY
    comp_auto = 0; hs_mode = 0;
    do_start(0, 63, 8, 0);
    wait_state(3'd5, 500, "t1_wait_replay");
    repeat (5) @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("t1_state", 64'(state_o), 0);
    chk("t1_start_replay", 64'(start_replay), 0);
    chk("t1_busy", 64'(busy), 0);
    chk("t1_addr_high", 64'(mem_addr_high), 0);
    chk("t1_stored", 64'(stored_cnt), 0);
    repeat (3) @(negedge clk);
    resetn = 1;

`ifdef DFLOW_CTRL_WATCHDOG_EN
    // Watchdog with no completion ever
    do_start(0, 63, 8, 0);
    rp0 = n_rp;
    wait_state(3'd5, 500, "t6_wait_replay");
    wait_state(3'd0, 300, "t6_wait_idle");
    @(negedge clk);
    chk("t6_timeout_err", 64'(timeout_err), 1);
    chk("t6_replay_cycles", 64'(n_rp - rp0), 100);
`else
    rp0 = n_rp;
`endif

    // Randomized runs against the model
    comp_auto = 1;
    for (int r = 0; r < 20; r++) begin
      int lo, hi, num, rc;
      lo = $urandom_range(0, 200);
      hi = lo + $urandom_range(0, 60);
      if ($urandom_range(0, 7) == 0 && lo > 0) hi = lo - 1;
      num = $urandom_range(0, 80);
      rc = $urandom_range(0, 3);
      hs_mode = $urandom_range(0, 2);
      init_calib_complete = 0;
      do_start(lo, hi, num, rc);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      init_calib_complete = 1;
      if (hi < lo) begin
        repeat (3) @(negedge clk);
      end else if (rc == 0 || $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(20, 300)) @(negedge clk);
        pulse_abort();
        repeat (3) @(negedge clk);
      end else begin
        wait_state(3'd7, 4000, "rand_wait_done");
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
